// File: rtl/bit_signed_divider_seq.sv
// Sequential signed divider: restoring division on operand magnitudes, one
// quotient bit per cycle, followed by a one-cycle sign fix-up.
//
// state  | meaning
// S_IDLE | ready for a new start; operands latched on EN_start
// S_CALC | one restoring-division iteration per cycle, WIDTH cycles
// S_FIX  | apply signs, divide-by-zero and overflow results
// S_DONE | result held on getResult until EN_getResult
module bit_signed_divider_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN_start,
  input  logic [WIDTH-1:0]     start_dividend,
  input  logic [WIDTH-1:0]     start_divisor,
  output logic                 RDY_start,
  input  logic                 EN_getResult,
  output logic [2*WIDTH+1:0]   getResult,
  output logic                 RDY_getResult
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_dvd;
  logic [WIDTH-1:0]     r_dsr;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_dividend;
  logic [CW-1:0]        r_cnt;
  logic                 r_sign_q;
  logic                 r_sign_r;
  logic                 r_dz;
  logic                 r_ovf;
  logic [2*WIDTH+1:0]   r_result;

  logic [WIDTH-1:0]     w_dvd_mag;
  logic [WIDTH-1:0]     w_dsr_mag;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH-1:0]     w_q_fix;
  logic [WIDTH-1:0]     w_r_fix;

  // Most-negative operand negates to itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    w_dvd_mag = start_dividend[WIDTH-1] ? -start_dividend : start_dividend;
    w_dsr_mag = start_divisor[WIDTH-1]  ? -start_divisor  : start_divisor;
    w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
    w_trial   = w_rem_sh - {1'b0, r_dsr};
    w_q_fix   = r_sign_q ? -r_dvd : r_dvd;
    w_r_fix   = r_sign_r ? -r_rem : r_rem;
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (EN_start) w_state_nxt = S_CALC;
      S_CALC: if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: if (EN_getResult) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dvd      <= '0;
      r_dsr      <= '0;
      r_rem      <= '0;
      r_dividend <= '0;
      r_cnt      <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_dz       <= 1'b0;
      r_ovf      <= 1'b0;
      r_result   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (EN_start) begin
            r_dvd      <= w_dvd_mag;
            r_dsr      <= w_dsr_mag;
            r_rem      <= '0;
            r_dividend <= start_dividend;
            r_cnt      <= CW'(WIDTH);
            r_sign_q   <= start_dividend[WIDTH-1] ^ start_divisor[WIDTH-1];
            r_sign_r   <= start_dividend[WIDTH-1];
            r_dz       <= (start_divisor == '0);
            r_ovf      <= (start_dividend == MOST_NEG) && (start_divisor == '1);
          end
        end
        S_CALC: begin
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_rem_sh[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          if (r_dz) r_result <= {2'b10, {WIDTH{1'b1}}, r_dividend};
          else      r_result <= {1'b0, r_ovf, w_q_fix, w_r_fix};
        end
        S_DONE: begin
          if (EN_getResult) r_result <= '0;
        end
        default: r_result <= '0;
      endcase
    end
  end

  assign RDY_start     = (r_state == S_IDLE);
  assign RDY_getResult = (r_state == S_DONE);
  assign getResult     = r_result;

endmodule

// File: tb/tb_bit_signed_divider_seq.sv
// Bench for bit_signed_divider_seq: directed sign/boundary/handshake/reset cases
// plus a randomized-order sweep of all WIDTH=4 operand pairs.
module tb_bit_signed_divider_seq;
  localparam int W  = 4;
  localparam int RW = 2*W + 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN_start = 1'b0;
  logic          EN_getResult = 1'b0;
  logic [W-1:0]  start_dividend = '0;
  logic [W-1:0]  start_divisor = '0;
  logic          RDY_start;
  logic          RDY_getResult;
  logic [RW-1:0] getResult;

  int            total = 0;
  int            bad = 0;
  logic [RW-1:0] m_exp = '0;

  bit_signed_divider_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST),
    .EN_start(EN_start), .start_dividend(start_dividend), .start_divisor(start_divisor),
    .RDY_start(RDY_start),
    .EN_getResult(EN_getResult), .getResult(getResult), .RDY_getResult(RDY_getResult)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: plain truncating division with C-style remainder.
  function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib, q, r;
    logic [W-1:0] qv, rv, ones;
    ia = $signed(a);
    ib = $signed(b);
    ones = '1;
    if (ib == 0) return {2'b10, ones, a};
    if (ia == -(1 << (W-1)) && ib == -1) return {2'b01, a, {W{1'b0}}};
    q = ia / ib;
    r = ia % ib;
    qv = q[W-1:0];
    rv = r[W-1:0];
    return {2'b00, qv, rv};
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      check("rdy_exclusive", {63'd0, RDY_start & RDY_getResult}, 64'd0);
      if (RDY_getResult) check("result_vs_model", getResult, m_exp);
      else               check("result_zero_when_not_done", getResult, 64'd0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < 50 && !RDY_start; i++) tick();
    check("start_ready", {63'd0, RDY_start}, 64'd1);
    EN_start = 1'b1;
    start_dividend = a;
    start_divisor = b;
    m_exp = model(a, b);
    tick();
    EN_start = 1'b0;
  endtask

  // Counts edges after the start edge until the result is ready.
  task automatic wait_ready(output int lat);
    lat = 0;
    while (!RDY_getResult && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    EN_getResult = 1'b1;
    tick();
    EN_getResult = 1'b0;
    check("idle_after_consume", {62'd0, RDY_start, RDY_getResult}, 64'd2);
  endtask

  task automatic run_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [RW-1:0] lit);
    int lat;
    launch(a, b);
    wait_ready(lat);
    check({name, "_latency"}, 64'(lat), 64'(W + 1));
    check(name, getResult, lit);
    consume();
  endtask

  initial begin
    int lat;
    int off;
    logic [7:0] p;

    tick(); tick();
    check("reset_state", {getResult, RDY_start, RDY_getResult}, {54'd0, 10'd0, 1'b1, 1'b0});
    RST = 1'b0;
    tick();

    check("model_7_2",   model(4'd7, 4'd2),   10'b00_0011_0001);
    check("model_m7_2",  model(4'h9, 4'd2),   10'b00_1101_1111);
    check("model_m8_m1", model(4'h8, 4'hF),   10'b01_1000_0000);
    check("model_5_0",   model(4'd5, 4'd0),   10'b10_1111_0101);

    run_lit("div_7_2",    4'd7, 4'd2, 10'b00_0011_0001);
    run_lit("div_m7_2",   4'h9, 4'd2, 10'b00_1101_1111);
    run_lit("div_7_m2",   4'd7, 4'hE, 10'b00_1101_0001);
    run_lit("div_m7_m2",  4'h9, 4'hE, 10'b00_0011_1111);
    run_lit("div_m8_m1",  4'h8, 4'hF, 10'b01_1000_0000);
    run_lit("div_5_0",    4'd5, 4'd0, 10'b10_1111_0101);

    // EN_getResult in IDLE must be ignored.
    EN_getResult = 1'b1;
    tick();
    EN_getResult = 1'b0;
    check("get_ignored_idle", {62'd0, RDY_start, RDY_getResult}, 64'd2);

    // Start during CALC ignored; original operands win.
    launch(4'd7, 4'd2);
    tick();
    EN_start = 1'b1;
    start_dividend = 4'd3;
    start_divisor = 4'd1;
    EN_getResult = 1'b1;
    tick();
    EN_start = 1'b0;
    EN_getResult = 1'b0;
    wait_ready(lat);
    check("busy_start_latency", 64'(lat + 2), 64'(W + 1));
    check("busy_start_ignored", getResult, 10'b00_0011_0001);

    // Back-pressure: result held while not consumed.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_ready", {63'd0, RDY_getResult}, 64'd1);
    end
    check("hold_value", getResult, 10'b00_0011_0001);

    // Simultaneous start+get in DONE: only the get takes effect.
    EN_getResult = 1'b1;
    EN_start = 1'b1;
    start_dividend = 4'd3;
    start_divisor = 4'd1;
    tick();
    EN_getResult = 1'b0;
    EN_start = 1'b0;
    check("simul_idle", {62'd0, RDY_start, RDY_getResult}, 64'd2);
    tick();
    check("simul_start_ignored", {62'd0, RDY_start, RDY_getResult}, 64'd2);

    // Reset during the third CALC cycle.
    launch(4'd7, 4'd2);
    tick();
    tick();
    RST = 1'b1;
    tick();
    check("reset_mid_calc", {getResult, RDY_start, RDY_getResult}, {54'd0, 10'd0, 1'b1, 1'b0});
    RST = 1'b0;
    run_lit("div_6_3", 4'd6, 4'd3, 10'b00_0010_0000);

    // Every operand pair, visited in a random rotation of an odd-stride order.
    off = int'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) begin
      p = 8'((i * 37 + off) % 256);
      launch(p[7:4], p[3:0]);
      wait_ready(lat);
      check("sweep_latency", 64'(lat), 64'(W + 1));
      check("sweep_result", getResult, model(p[7:4], p[3:0]));
      for (int d = int'($urandom_range(0, 2)); d > 0; d--) tick();
      consume();
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete, got stuck want finish");
    $fatal(1, "timeout");
  end
endmodule
